// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the divider issue/capture controller.
package div_pkg;

   localparam int unsigned DIV_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DONE
   } div_state_t;

   localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 4'hF;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Decode request / writeback response handshakes for div_seq_ctrl.
// resp_ovf exists only when DIV_SIGNED_EN is defined.
interface div_seq_ctrl_if #(
   parameter int unsigned RD_W = 3
);
   import div_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic [DIV_W-1:0] req_a;
   logic [DIV_W-1:0] req_b;
   logic [RD_W-1:0]  req_rd;

   logic             resp_valid;
   logic             resp_ready;
   logic [DIV_W-1:0] resp_quotient;
   logic [DIV_W-1:0] resp_remainder;
   logic [RD_W-1:0]  resp_rd;
   logic             resp_dbz;
`ifdef DIV_SIGNED_EN
   logic             resp_ovf;

   modport master (
      output req_valid, req_a, req_b, req_rd, resp_ready,
      input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_rd,
             resp_dbz, resp_ovf
   );

   modport slave (
      input  req_valid, req_a, req_b, req_rd, resp_ready,
      output req_ready, resp_valid, resp_quotient, resp_remainder, resp_rd,
             resp_dbz, resp_ovf
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_rd, resp_ready,
      input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_rd,
             resp_dbz
   );

   modport slave (
      input  req_valid, req_a, req_b, req_rd, resp_ready,
      output req_ready, resp_valid, resp_quotient, resp_remainder, resp_rd,
             resp_dbz
   );
`endif

endinterface

// File: rtl/div_seq_ctrl_sign_fix.sv
// Two's-complement wrapper logic around the unsigned divider.
// Compiled only when DIV_SIGNED_EN is defined.
`ifdef DIV_SIGNED_EN
module div_sign_fix
   import div_pkg::*;
(
   input  logic [DIV_W-1:0] i_a,
   input  logic [DIV_W-1:0] i_b,
   output logic [DIV_W-1:0] o_mag_a,
   output logic [DIV_W-1:0] o_mag_b,
   output logic             o_neg_q,
   output logic             o_neg_r,

   input  logic             i_neg_q,
   input  logic             i_neg_r,
   input  logic [DIV_W-1:0] i_div_a,
   input  logic [DIV_W-1:0] i_div_b,
   input  logic [DIV_W-1:0] i_quotient,
   input  logic [DIV_W-1:0] i_remainder,
   output logic [DIV_W-1:0] o_quotient,
   output logic [DIV_W-1:0] o_remainder,
   output logic             o_ovf
);

   // -8 has no positive 4-bit form; its magnitude wraps to 4'b1000 as intended.
   assign o_mag_a = i_a[DIV_W-1] ? (~i_a + 1'b1) : i_a;
   assign o_mag_b = i_b[DIV_W-1] ? (~i_b + 1'b1) : i_b;
   assign o_neg_q = i_a[DIV_W-1] ^ i_b[DIV_W-1];
   assign o_neg_r = i_a[DIV_W-1];

   assign o_quotient  = i_neg_q ? (~i_quotient + 1'b1) : i_quotient;
   assign o_remainder = i_neg_r ? (~i_remainder + 1'b1) : i_remainder;

   // Only -8 / -1 gives |a| = 8, |b| = 1 with both operands negative.
   assign o_ovf = i_neg_r && !i_neg_q && (i_div_a == 4'h8) && (i_div_b == 4'h1);

endmodule
`endif

// File: rtl/div_seq_ctrl.sv
// Issue/capture controller for the 4-bit combinational array divider.
// Define DIV_SIGNED_EN for two's-complement operation with resp_ovf.
module div_seq_ctrl
   import div_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned RD_W          = 3
) (
   input  logic             clk,
   input  logic             rst,
   div_seq_ctrl_if.slave    bus,
   output logic [DIV_W-1:0] div_a,
   output logic [DIV_W-1:0] div_b,
   input  logic [DIV_W-1:0] div_quotient,
   input  logic [DIV_W-1:0] div_remainder
);

   localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

   div_state_t       r_state;
   logic [3:0]       r_cnt;
   logic [DIV_W-1:0] r_div_a;
   logic [DIV_W-1:0] r_div_b;
   logic [DIV_W-1:0] r_quotient;
   logic [DIV_W-1:0] r_remainder;
   logic [RD_W-1:0]  r_rd;
   logic             r_dbz;
   logic             r_valid;

   logic [DIV_W-1:0] w_op_a;
   logic [DIV_W-1:0] w_op_b;
   logic [DIV_W-1:0] w_cap_q;
   logic [DIV_W-1:0] w_cap_r;

`ifdef DIV_SIGNED_EN
   logic r_neg_q;
   logic r_neg_r;
   logic r_ovf;
   logic w_neg_q;
   logic w_neg_r;
   logic w_cap_ovf;

   div_sign_fix u_sign_fix (
      .i_a         (bus.req_a),
      .i_b         (bus.req_b),
      .o_mag_a     (w_op_a),
      .o_mag_b     (w_op_b),
      .o_neg_q     (w_neg_q),
      .o_neg_r     (w_neg_r),
      .i_neg_q     (r_neg_q),
      .i_neg_r     (r_neg_r),
      .i_div_a     (r_div_a),
      .i_div_b     (r_div_b),
      .i_quotient  (div_quotient),
      .i_remainder (div_remainder),
      .o_quotient  (w_cap_q),
      .o_remainder (w_cap_r),
      .o_ovf       (w_cap_ovf)
   );

   assign bus.resp_ovf = r_ovf;
`else
   assign w_op_a  = bus.req_a;
   assign w_op_b  = bus.req_b;
   assign w_cap_q = div_quotient;
   assign w_cap_r = div_remainder;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_div_a     <= '0;
         r_div_b     <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_rd        <= '0;
         r_dbz       <= 1'b0;
         r_valid     <= 1'b0;
`ifdef DIV_SIGNED_EN
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_ovf       <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_rd <= bus.req_rd;
                  if (bus.req_b == '0) begin
                     r_quotient  <= DBZ_QUOTIENT;
                     r_remainder <= bus.req_a;
                     r_dbz       <= 1'b1;
                     r_valid     <= 1'b1;
`ifdef DIV_SIGNED_EN
                     r_ovf       <= 1'b0;
`endif
                     r_state     <= DONE;
                  end else begin
                     r_div_a <= w_op_a;
                     r_div_b <= w_op_b;
                     r_cnt   <= '0;
`ifdef DIV_SIGNED_EN
                     r_neg_q <= w_neg_q;
                     r_neg_r <= w_neg_r;
`endif
                     r_state <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == LAST_CNT) begin
                  r_quotient  <= w_cap_q;
                  r_remainder <= w_cap_r;
                  r_dbz       <= 1'b0;
                  r_valid     <= 1'b1;
`ifdef DIV_SIGNED_EN
                  r_ovf       <= w_cap_ovf;
`endif
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.resp_ready) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready      = (r_state == IDLE) && !rst;
   assign bus.resp_valid     = r_valid;
   assign bus.resp_quotient  = r_quotient;
   assign bus.resp_remainder = r_remainder;
   assign bus.resp_rd        = r_rd;
   assign bus.resp_dbz       = r_dbz;
   assign div_a              = r_div_a;
   assign div_b              = r_div_b;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl with a behavioural divider beside it.
// Define DIV_SIGNED_EN to exercise the signed build.
module tb_div_seq_ctrl;
   import div_pkg::*;

   localparam int unsigned SC   = 2;
   localparam int unsigned RDW  = 3;

   typedef struct {
      logic [3:0]     q;
      logic [3:0]     r;
      logic [RDW-1:0] rd;
      logic           dbz;
      logic           ovf;
      int             lat;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] div_a;
   logic [3:0] div_b;
   logic [3:0] div_quotient;
   logic [3:0] div_remainder;

   int n_checks;
   int n_fail;
   exp_t exp_q[$];

   div_seq_ctrl_if #(.RD_W(RDW)) bus ();

   div_seq_ctrl #(.SETTLE_CYCLES(SC), .RD_W(RDW)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .div_a         (div_a),
      .div_b         (div_b),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder)
   );

   // Behavioural array divider (unsigned).
   always_comb begin
      div_quotient  = 4'hF;
      div_remainder = div_a;
      if (div_b != 4'h0) begin
         div_quotient  = div_a / div_b;
         div_remainder = div_a % div_b;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input logic [3:0] a, input logic [3:0] b, input logic [RDW-1:0] rd);
      exp_t e;
      int sa;
      int sb;
      e.rd  = rd;
      e.dbz = (b == 4'h0);
      e.ovf = 1'b0;
      e.lat = (b == 4'h0) ? 1 : int'(SC) + 1;
      if (b == 4'h0) begin
         e.q = 4'hF;
         e.r = a;
      end else begin
`ifdef DIV_SIGNED_EN
         sa = a[3] ? int'(a) - 16 : int'(a);
         sb = b[3] ? int'(b) - 16 : int'(b);
         if (sa == -8 && sb == -1) begin
            e.q   = 4'h8;
            e.r   = 4'h0;
            e.ovf = 1'b1;
         end else begin
            e.q = 4'(sa / sb);
            e.r = 4'(sa % sb);
         end
`else
         sa  = int'(a);
         sb  = int'(b);
         e.q = 4'(sa / sb);
         e.r = 4'(sa % sb);
`endif
      end
      exp_q.push_back(e);
   endtask

   task automatic drive_req(input logic [3:0] a, input logic [3:0] b, input logic [RDW-1:0] rd);
      int n;
      @(negedge clk);
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_rd    = rd;
      bus.req_valid = 1'b1;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL req_accept_timeout: req_ready=%b required 1", bus.req_ready);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   // Called 1 time unit after the accept edge; that edge counts as clock 1.
   task automatic wait_resp(input int delay);
      exp_t e;
      int n;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: no expected entry queued");
         return;
      end
      e = exp_q.pop_front();
      bus.resp_ready = (delay == 0);
      n = 1;
      while (bus.resp_valid !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (bus.resp_valid !== 1'b1 || n != e.lat) begin
         n_fail++;
         $display("FAIL latency: valid=%b clocks=%0d required %0d", bus.resp_valid, n, e.lat);
      end
      n_checks++;
      if (bus.resp_quotient !== e.q || bus.resp_remainder !== e.r) begin
         n_fail++;
         $display("FAIL result: q=%h r=%h required q=%h r=%h",
                  bus.resp_quotient, bus.resp_remainder, e.q, e.r);
      end
      n_checks++;
      if (bus.resp_rd !== e.rd || bus.resp_dbz !== e.dbz) begin
         n_fail++;
         $display("FAIL tag_dbz: rd=%h dbz=%b required rd=%h dbz=%b",
                  bus.resp_rd, bus.resp_dbz, e.rd, e.dbz);
      end
`ifdef DIV_SIGNED_EN
      n_checks++;
      if (bus.resp_ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL ovf: ovf=%b required %b", bus.resp_ovf, e.ovf);
      end
`endif
      for (int i = 0; i < delay; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
             bus.resp_quotient !== e.q || bus.resp_remainder !== e.r ||
             bus.resp_rd !== e.rd || bus.resp_dbz !== e.dbz) begin
            n_fail++;
            $display("FAIL hold_stable: cyc=%0d valid=%b rdy=%b q=%h r=%h required 1 0 %h %h",
                     i, bus.resp_valid, bus.req_ready, bus.resp_quotient, bus.resp_remainder,
                     e.q, e.r);
         end
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL return_idle: valid=%b req_ready=%b required 0 1",
                  bus.resp_valid, bus.req_ready);
      end
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_rd     = '0;
      bus.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_handshake: req_ready=%b resp_valid=%b required 0 0",
                  bus.req_ready, bus.resp_valid);
      end
      n_checks++;
      if (div_a !== 4'h0 || div_b !== 4'h0 || bus.resp_quotient !== 4'h0 ||
          bus.resp_remainder !== 4'h0 || bus.resp_rd !== '0 || bus.resp_dbz !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: a=%h b=%h q=%h r=%h rd=%h dbz=%b required all 0",
                  div_a, div_b, bus.resp_quotient, bus.resp_remainder, bus.resp_rd, bus.resp_dbz);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: req_ready=%b required 1", bus.req_ready);
      end
   endtask

   task automatic test_unsigned();
      push_exp(4'd13, 4'd3, 3'd2);
      drive_req(4'd13, 4'd3, 3'd2);
      wait_resp(0);
   endtask

   task automatic test_dbz();
      logic [3:0] old_a;
      logic [3:0] old_b;
      old_a = div_a;
      old_b = div_b;
      push_exp(4'd7, 4'd0, 3'd5);
      drive_req(4'd7, 4'd0, 3'd5);
      n_checks++;
      if (div_a !== old_a || div_b !== old_b) begin
         n_fail++;
         $display("FAIL dbz_div_hold: a=%h b=%h required %h %h", div_a, div_b, old_a, old_b);
      end
      wait_resp(0);
   endtask

   task automatic test_backpressure();
      push_exp(4'd15, 4'd4, 3'd3);
      drive_req(4'd15, 4'd4, 3'd3);
      wait_resp(5);
   endtask

   task automatic test_reset_abort();
      drive_req(4'd9, 4'd2, 3'd7);
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (div_a !== 4'h0 || div_b !== 4'h0 || bus.resp_valid !== 1'b0 ||
          bus.req_ready !== 1'b0 || bus.resp_quotient !== 4'h0 ||
          bus.resp_remainder !== 4'h0 || bus.resp_rd !== '0 || bus.resp_dbz !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_reset: a=%h b=%h valid=%b rdy=%b q=%h r=%h rd=%h required all 0",
                  div_a, div_b, bus.resp_valid, bus.req_ready, bus.resp_quotient,
                  bus.resp_remainder, bus.resp_rd);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_resp: cyc=%0d valid=%b rdy=%b required 0 1",
                     i, bus.resp_valid, bus.req_ready);
         end
      end
      push_exp(4'd9, 4'd2, 3'd6);
      drive_req(4'd9, 4'd2, 3'd6);
      wait_resp(0);
   endtask

   task automatic test_back_to_back();
      logic [3:0] old_a;
      exp_t e;
      old_a = div_a;
      push_exp(4'd5, 4'd0, 3'd1);
      drive_req(4'd5, 4'd0, 3'd1);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_quotient !== e.q || bus.resp_remainder !== e.r) begin
         n_fail++;
         $display("FAIL b2b_first: valid=%b q=%h r=%h required 1 %h %h",
                  bus.resp_valid, bus.resp_quotient, bus.resp_remainder, e.q, e.r);
      end
      bus.req_a      = 4'd6;
      bus.req_b      = 4'd3;
      bus.req_rd     = 3'd2;
      bus.req_valid  = 1'b1;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || div_a !== old_a) begin
         n_fail++;
         $display("FAIL b2b_handshake_edge: valid=%b rdy=%b div_a=%h required 0 1 %h",
                  bus.resp_valid, bus.req_ready, div_a, old_a);
      end
      bus.resp_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      n_checks++;
      if (bus.req_ready !== 1'b0 || div_a !== 4'd6 || div_b !== 4'd3) begin
         n_fail++;
         $display("FAIL b2b_next_accept: rdy=%b a=%h b=%h required 0 6 3",
                  bus.req_ready, div_a, div_b);
      end
      push_exp(4'd6, 4'd3, 3'd2);
      wait_resp(0);
   endtask

   task automatic test_random();
      logic [3:0]     a;
      logic [3:0]     b;
      logic [RDW-1:0] rd;
      for (int i = 0; i < 8; i++) begin
         a  = 4'($urandom_range(0, 15));
         b  = 4'($urandom_range(0, 15));
         rd = RDW'($urandom_range(0, 7));
         push_exp(a, b, rd);
         drive_req(a, b, rd);
         wait_resp(int'($urandom_range(0, 2)));
      end
   endtask

`ifdef DIV_SIGNED_EN
   task automatic test_signed();
      push_exp(4'h9, 4'h2, 3'd4);
      drive_req(4'h9, 4'h2, 3'd4);
      wait_resp(0);
      push_exp(4'h8, 4'hF, 3'd5);
      drive_req(4'h8, 4'hF, 3'd5);
      wait_resp(1);
      push_exp(4'h8, 4'h0, 3'd1);
      drive_req(4'h8, 4'h0, 3'd1);
      wait_resp(0);
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_unsigned();
      test_dbz();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
`ifdef DIV_SIGNED_EN
      test_signed();
`endif
      test_random();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequential issue/capture controller for the ALU's 4-bit combinational array divider. It accepts a divide request from decode over a valid/ready handshake and registers the operands onto the divider inputs. It holds them for a fixed settle window, then captures quotient/remainder and presents them to register-file writeback over a second valid/ready handshake. Divide-by-zero bypasses the divider entirely.

## Interface
Parameters:
- SETTLE_CYCLES, 2: cycles operands are held on the divider before capture; legal range 1..15.
- RD_W, 3: destination-register tag width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  decode has a divide request.
- req_ready  out  1  controller can accept a request.
- req_a  in  4  dividend.
- req_b  in  4  divisor.
- req_rd  in  RD_W  destination tag.
- div_a  out  4  registered dividend to divider.
- div_b  out  4  registered divisor to divider.
- div_quotient  in  4  divider quotient.
- div_remainder  in  4  divider remainder.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts result.
- resp_quotient  out  4  registered quotient.
- resp_remainder  out  4  registered remainder.
- resp_rd  out  RD_W  tag of this result.
- resp_dbz  out  1  divisor was zero.
- resp_ovf  out  1  signed overflow (exists only with DIV_SIGNED_EN).

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE:
  - req_ready = 1 (0 while rst asserted).
  - On req_valid && req_ready: latch req_rd.
  - If req_b == 0: load resp_quotient = 4'hF, resp_remainder = req_a, resp_dbz = 1, and go to DONE. div_a/div_b are unchanged.
  - Otherwise: load div_a/div_b, clear settle counter to 0, and go to SETTLE.
- SETTLE:
  - req_ready = 0. The counter increments each cycle.
  - In the cycle where counter == SETTLE_CYCLES-1: capture div_quotient/div_remainder into resp_*, set resp_dbz = 0, and go to DONE.
- DONE:
  - resp_valid = 1. All resp_* are held stable until resp_ready.
  - On resp_valid && resp_ready: go to IDLE.
  - No request is accepted in DONE, so maximum one divide in flight.
- div_a/div_b hold their last value outside SETTLE; the divider output is don't-care then.
- Widths: all arithmetic is 4-bit unsigned. The counter is 4 bits.

## Timing
- Reset (async): state IDLE; div_a, div_b, resp_quotient, resp_remainder, resp_rd, resp_dbz, resp_ovf, resp_valid and counter all 0.
- req_ready is combinational from state and rst.
- Latency, accept edge to resp_valid high:
  - Normal: SETTLE_CYCLES+1 clocks.
  - Divide-by-zero: 1 clock.
- Back-to-back: after a response handshake at edge N, the earliest next acceptance is edge N+1.
- req_valid in SETTLE/DONE is ignored; the requester must hold it.
- Reset mid-SETTLE or mid-DONE aborts the operation. No response is produced and the tag is lost.
- resp_ready held low: stays in DONE indefinitely with all outputs stable.

## Configuration
- DIV_SIGNED_EN undefined: unsigned divide as above; resp_ovf port absent.
- DIV_SIGNED_EN defined: operands are two's complement.
  - div_a/div_b carry magnitudes; a magnitude of 8 encodes as 4'b1000.
  - Quotient is negated when sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
  - Sign correction is applied at capture.
  - resp_ovf = 1 only for -8 / -1; quotient is then 4'h8 and remainder 0.
  - Divide-by-zero result is unchanged (quotient 4'hF = -1, remainder = a, ovf = 0).

## Structure
- Shared package div_pkg holds:
  - DIV_W = 4.
  - The state enum div_state_t (IDLE, SETTLE, DONE).
  - DBZ_QUOTIENT = 4'hF.
- One sub-module, div_sign_fix, is compiled only under DIV_SIGNED_EN:
  - Operand abs-value on the request side.
  - Result negation and overflow detection on the capture side.
- The divider itself is instantiated beside this block at ALU level, not inside it.

## Test plan
- Unsigned 13/3, SETTLE_CYCLES=2, resp_ready=1 -> resp_valid 3 clocks after accept; q=4'h4, r=4'h1, dbz=0.
- 7/0 -> resp_valid 1 clock after accept; q=4'hF, r=4'h7, dbz=1; div_a/div_b unchanged.
- 15/4 with resp_ready low 5 cycles -> q=4'h3, r=4'h3 held stable; req_ready=0 throughout; returns to IDLE the cycle after resp_ready rises.
- Reset asserted during SETTLE of 9/2 -> all outputs 0 immediately; no resp_valid; next request 9/2 -> q=4'h4, r=4'h1.
- DIV_SIGNED_EN, -7/2 (4'h9/4'h2) -> q=4'hD, r=4'hF, ovf=0.
- DIV_SIGNED_EN, -8/-1 (4'h8/4'hF) -> q=4'h8, r=4'h0, ovf=1.
